// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding and default sizing shared by the UART receiver and its benches.
package uart_rx_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the async rx line, resets to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, 8N1 by default, 8E1 with parity_err when UART_RX_PARITY_EN is defined.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  logic rx_s;
  logic [2:0] state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic mid, fin, stop_smp, valid_nxt, ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic par_bad, perr_nxt;
`endif

  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));

  assign mid = tick_cnt == TW'(OVERSAMPLE / 2 - 1);
  assign fin = tick_cnt == TW'(OVERSAMPLE - 1);

  always_comb begin
    state_nxt = state;
    if (baud_tick)
      case (state)
        S_IDLE:      if (!rx_s) state_nxt = S_START;
        S_START:     if (mid) state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
        S_DATA:      if (fin && bit_cnt == BW'(DATA_BITS - 1)) state_nxt = S_PARITY;
        S_PARITY:    if (fin) state_nxt = S_STOP;
`else
        S_DATA:      if (fin && bit_cnt == BW'(DATA_BITS - 1)) state_nxt = S_STOP;
`endif
        S_STOP:      if (fin) state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
        S_WAIT_IDLE: if (rx_s) state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
  end

  always_comb begin
    busy = state != S_IDLE;
    stop_smp = baud_tick && state == S_STOP && fin;
    ferr_nxt = stop_smp && !rx_s;
`ifdef UART_RX_PARITY_EN
    valid_nxt = stop_smp && rx_s && !par_bad;
    perr_nxt = stop_smp && par_bad;
`else
    valid_nxt = stop_smp && rx_s;
`endif
  end

  // Counters restart on every state change so each state measures from its own entry tick.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= valid_nxt;
      frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_nxt;
      if (baud_tick && state == S_PARITY && fin) par_bad <= ^{shift_reg, rx_s};
`endif
      if (valid_nxt) rx_data <= shift_reg;
      if (baud_tick) begin
        state <= state_nxt;
        tick_cnt <= (state_nxt != state || fin || state == S_IDLE || state == S_WAIT_IDLE) ? '0 : tick_cnt + TW'(1);
        bit_cnt <= state_nxt != state ? '0 : bit_cnt + BW'(state == S_DATA && fin);
        if (state == S_DATA && fin) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frame stimulus with a queue scoreboard; expected outcomes come from frame-level rules.
module tb_uart_rx_core;
  typedef struct packed {
    logic       good;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, baud_tick = 1'b0, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int div = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t sb[$];
  logic [7:0] last = 8'h00;

  uart_rx_core dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div <= (div + 1) % 4;
    baud_tick <= div == 3;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (64) @(negedge clk);
  endtask

  // Outcome rule: a frame is accepted only if its stop bit is high (and its parity is even, when present);
  // otherwise the previously accepted byte stays on rx_data.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip, input int gap);
    exp_t e;
    logic ok;
    ok = stop_b;
`ifdef UART_RX_PARITY_EN
    ok = stop_b && !par_flip;
`endif
    e.good = ok;
    e.data = ok ? d : last;
    if (ok) last = d;
    sb.push_back(e);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_wait();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    bit_wait();
`endif
    rx = stop_b;
    bit_wait();
    rx = 1'b1;
    repeat (gap) bit_wait();
  endtask

  always @(negedge clk) begin
    exp_t e;
`ifdef UART_RX_PARITY_EN
    if (rst_n && (rx_valid || frame_err || parity_err)) begin
`else
    if (rst_n && (rx_valid || frame_err)) begin
`endif
      chk("valid_ferr_overlap", {31'd0, rx_valid & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", {31'd0, rx_valid}, {31'd0, e.good});
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        if (e.good) chk("busy_at_valid", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation timeout, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int bcnt;
    repeat (5) @(negedge clk);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    bit_wait();
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 1);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    bcnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("glitch_busy_seen", {31'd0, bcnt > 0}, 32'd1);
    chk("glitch_busy_short", {31'd0, bcnt <= 36}, 32'd1);
    chk("glitch_idle_after", {31'd0, busy}, 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    send_frame(8'h11, 1'b1, 1'b0, 1);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      bit_wait();
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midreset_valid", {31'd0, rx_valid}, 32'd0);
    chk("midreset_ferr", {31'd0, frame_err}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    last = 8'h00;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bit_wait();
    chk("postreset_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1);
    send_frame(8'h07, 1'b1, 1'b1, 1);
`endif
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic s, f;
      d = 8'($urandom);
      s = $urandom_range(0, 5) != 0;
      f = $urandom_range(0, 3) == 0;
      send_frame(d, s, f, s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
